// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared constants, types and address packing for the frame-buffer
//            port scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int PIX_W     = 12;
  localparam int FB_W_LOG2 = 8;
  localparam int FB_H      = 192;
  localparam int FB_ADDR_W = FB_W_LOG2 + 8;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_DISPLAY = 2'd1,
    OWN_CLEAR   = 2'd2,
    OWN_WRITER  = 2'd3
  } owner_t;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  // Row-major frame-buffer address of quarter-resolution pixel (x, y).
  function automatic logic [FB_ADDR_W-1:0] pack_addr(input logic [7:0] x,
                                                     input logic [7:0] y);
    return (FB_ADDR_W'(y) << FB_W_LOG2) | FB_ADDR_W'(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_blank_delay.sv
`default_nettype none
// ============================================================================
// Module   : fb_blank_delay
// Purpose  : DEPTH-stage shift register carrying blank; resets to blanked.
// Revision : 1.0 - initial release
// ============================================================================
module fb_blank_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_blank,
  output logic o_blank
);

  logic [DEPTH-1:0] r_shift;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) r_shift <= '1;
        else     r_shift <= i_blank;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) r_shift <= '1;
        else     r_shift <= {r_shift[DEPTH-2:0], i_blank};
      end
    end
  endgenerate

  assign o_blank = r_shift[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_scheduler
// Purpose  : Time-shares one single-port frame-buffer RAM between scan-out,
//            a frame-clear sweep and a valid/ready pixel writer.
// Revision : 1.0 - initial release
// ============================================================================
module fb_port_scheduler #(
  parameter int PIX_W        = fb_pkg::PIX_W,
  parameter int READ_LATENCY = 2,
  parameter int FB_W_LOG2    = fb_pkg::FB_W_LOG2,
  parameter int FB_H         = fb_pkg::FB_H,
  parameter int ADDR_W       = FB_W_LOG2 + 8
) (
  input  logic              vclock,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              blank,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_value,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pixel_out
);

  import fb_pkg::*;

  localparam int                c_lat       = READ_LATENCY + 2;
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_H * (2 ** FB_W_LOG2) - 1);

  owner_t            w_owner;
  clr_state_t        r_clr_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [PIX_W-1:0]  r_clr_value;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_blank_dly;
  logic              w_unused;

  assign w_disp_addr = ADDR_W'(pack_addr(hcount[9:2], vcount[9:2]));
  assign w_unused    = ^{hcount[10], hcount[1:0], vcount[1:0]};

  always_comb begin
    w_owner = OWN_NONE;
    if (!blank)          w_owner = OWN_DISPLAY;
    else if (clear_busy) w_owner = OWN_CLEAR;
    else if (wr_valid)   w_owner = OWN_WRITER;
  end

  assign wr_ready = blank & ~clear_busy & ~reset;

  always_ff @(posedge vclock) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (w_owner)
        OWN_DISPLAY: mem_addr <= w_disp_addr;
        OWN_CLEAR: begin
          mem_addr  <= r_clr_cnt;
          mem_we    <= 1'b1;
          mem_wdata <= r_clr_value;
        end
        OWN_WRITER: begin
          mem_addr  <= wr_addr;
          mem_we    <= 1'b1;
          mem_wdata <= wr_data;
        end
        default: ;
      endcase
    end
  end

  // A restart takes precedence over finishing, so no done pulse accompanies it.
  always_ff @(posedge vclock) begin
    if (reset) begin
      r_clr_state <= CLR_IDLE;
      r_clr_cnt   <= '0;
      r_clr_value <= '0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (r_clr_state)
        CLR_IDLE: begin
          if (clear_req) begin
            r_clr_state <= CLR_SWEEP;
            r_clr_cnt   <= '0;
            r_clr_value <= clear_value;
            clear_busy  <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (clear_req) begin
            r_clr_cnt   <= '0;
            r_clr_value <= clear_value;
          end else if (w_owner == OWN_CLEAR) begin
            if (r_clr_cnt == c_last_addr) begin
              r_clr_state <= CLR_IDLE;
              clear_busy  <= 1'b0;
              clear_done  <= 1'b1;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end
        default: r_clr_state <= CLR_IDLE;
      endcase
    end
  end

  // The pixel_out register supplies the final stage of blank alignment.
  fb_blank_delay #(
    .DEPTH (c_lat - 1)
  ) u_blank_delay (
    .clk     (vclock),
    .rst     (reset),
    .i_blank (blank),
    .o_blank (w_blank_dly)
  );

  always_ff @(posedge vclock) begin
    if (reset)            pixel_out <= '0;
    else if (w_blank_dly) pixel_out <= '0;
    else                  pixel_out <= mem_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_port_scheduler
// Purpose  : Randomised self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_port_scheduler;

  localparam int PIX_W        = 12;
  localparam int READ_LATENCY = 2;
  localparam int LAT          = READ_LATENCY + 2;
  localparam int ADDR_W       = 16;
  localparam int NWORDS       = 192 * 256;

  logic              vclock = 1'b0;
  logic              reset = 1'b1;
  logic [10:0]       hcount = '0;
  logic [9:0]        vcount = '0;
  logic              blank = 1'b1;
  logic              clear_req = 1'b0;
  logic [PIX_W-1:0]  clear_value = '0;
  logic              clear_busy, clear_done;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PIX_W-1:0]  pixel_out;

  always #5 vclock = ~vclock;

  fb_port_scheduler #(
    .PIX_W(PIX_W), .READ_LATENCY(READ_LATENCY), .FB_W_LOG2(8), .FB_H(192), .ADDR_W(ADDR_W)
  ) dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount), .blank(blank),
    .clear_req(clear_req), .clear_value(clear_value), .clear_busy(clear_busy),
    .clear_done(clear_done), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel_out(pixel_out)
  );

  function automatic logic [11:0] init_val(input logic [15:0] a);
    return 12'((int'(a) * 37 + 11) ^ (int'(a) >> 4));
  endfunction

  // RAM environment: power-up contents come from init_val until written.
  logic [11:0] ram [0:65535];
  bit          written [0:65535];
  logic [11:0] rd_pipe [0:READ_LATENCY-1];
  always @(posedge vclock) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[READ_LATENCY-1];

  // Reference model state
  logic [11:0] mmem [0:65535];
  logic [11:0] pixq [$];
  int          m_cnt;
  logic [11:0] m_val;
  logic [15:0] e_addr;
  logic        e_we, e_busy, e_done;
  logic [11:0] e_wdata, e_pix;

  // Stimulus for the next cycle
  logic        s_rst, s_blank, s_creq, s_wv;
  logic [10:0] s_h;
  logic [9:0]  s_v;
  logic [11:0] s_cval, s_wd;
  logic [15:0] s_wa;

  int n_checks = 0;
  int n_errors = 0;
  int sb [0:65535];
  bit sb_on = 1'b0;
  int done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    s_rst = 0; s_blank = 1; s_creq = 0; s_wv = 0;
    s_h = '0; s_v = '0; s_cval = '0; s_wd = '0; s_wa = '0;
  endtask

  // One clock: drive, check wr_ready, advance the model, check registered outputs.
  task automatic step();
    int  daddr;
    bit  clr_issued;
    reset = s_rst; blank = s_blank; hcount = s_h; vcount = s_v;
    clear_req = s_creq; clear_value = s_cval;
    wr_valid = s_wv; wr_addr = s_wa; wr_data = s_wd;
    #1;
    check_eq("wr_ready", wr_ready, s_blank & ~e_busy & ~s_rst);
    clr_issued = 0;
    if (s_rst) begin
      e_addr = 0; e_we = 0; e_wdata = 0; e_busy = 0; e_done = 0; m_cnt = 0;
      pixq.delete();
      repeat (LAT - 1) pixq.push_back(12'h000);
      e_pix = 0;
    end else begin
      e_done = 0;
      e_we   = 0;
      daddr  = int'(s_v / 4) * 256 + int'(s_h[9:0] / 4);
      if (!s_blank) begin
        e_addr = 16'(daddr);
        pixq.push_back(mmem[daddr]);
      end else begin
        pixq.push_back(12'h000);
        if (e_busy) begin
          e_addr = 16'(m_cnt); e_we = 1; e_wdata = m_val; mmem[m_cnt] = m_val;
          clr_issued = 1;
        end else if (s_wv) begin
          e_addr = s_wa; e_we = 1; e_wdata = s_wd; mmem[s_wa] = s_wd;
        end
      end
      e_pix = pixq.pop_front();
      if (e_busy) begin
        if (s_creq) begin
          m_cnt = 0; m_val = s_cval;
        end else if (clr_issued) begin
          if (m_cnt == NWORDS - 1) begin e_done = 1; e_busy = 0; end
          else m_cnt++;
        end
      end else if (s_creq) begin
        e_busy = 1; m_cnt = 0; m_val = s_cval;
      end
    end
    @(posedge vclock);
    #1;
    check_eq("mem_we", mem_we, e_we);
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wdata", mem_wdata, e_wdata);
    check_eq("clear_busy", clear_busy, e_busy);
    check_eq("clear_done", clear_done, e_done);
    check_eq("pixel_out", pixel_out, e_pix);
    if (sb_on && mem_we) sb[mem_addr]++;
    if (clear_done) begin
      done_cnt++;
      if (sb_on) check_eq("done_addr", mem_addr, NWORDS - 1);
    end
  endtask

  initial begin
    int bad;
    int phase;
    for (int i = 0; i < 65536; i++) mmem[i] = init_val(16'(i));
    e_busy = 0; m_cnt = 0; m_val = 0;

    // Reset
    idle(); s_rst = 1;
    repeat (3) step();
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_pixel", pixel_out, 0);
    check_eq("rst_busy", clear_busy, 0);

    // Write a pixel, then scan it out
    idle(); s_wv = 1; s_wa = 16'h0102; s_wd = 12'hABC; step();
    idle(); step();
    idle(); s_blank = 0; s_h = 11'd8; s_v = 10'd4; step();
    check_eq("t1_addr", mem_addr, 16'h0102);
    check_eq("t1_we", mem_we, 0);
    idle(); repeat (2) step();
    check_eq("t1_pix_early", pixel_out, 0);
    step();
    check_eq("t1_pix", pixel_out, 12'hABC);

    // Writer held off during active video
    idle(); s_blank = 0; s_wv = 1; s_wa = 16'h1234; s_wd = 12'h0F0; s_h = 11'd100; s_v = 10'd40;
    repeat (3) begin
      step();
      check_eq("t2_we_active", mem_we, 0);
    end
    s_blank = 1; step();
    check_eq("t2_we", mem_we, 1);
    check_eq("t2_addr", mem_addr, 16'h1234);
    check_eq("t2_wdata", mem_wdata, 12'h0F0);

    // Randomised mixed traffic
    for (int i = 0; i < 1500; i++) begin
      idle();
      s_rst   = ($urandom_range(0, 299) == 0);
      s_blank = ($urandom_range(0, 2) != 0);
      s_h     = 11'($urandom_range(0, 1023));
      s_v     = 10'($urandom_range(0, 767));
      s_creq  = ($urandom_range(0, 99) == 0);
      s_cval  = 12'($urandom);
      s_wv    = 1'($urandom);
      s_wa    = 16'($urandom);
      s_wd    = 12'($urandom);
      step();
    end
    idle(); s_rst = 1; step();

    // Clear, restart at 1000, then finish half in vblank and half across active lines
    idle(); s_creq = 1; s_cval = 12'h5A5; step();
    for (int i = 0; i < 2000 && m_cnt != 1000; i++) begin
      idle(); s_wv = 1'($urandom); s_wa = 16'($urandom); step();
    end
    check_eq("restart_point", m_cnt, 1000);
    idle(); s_creq = 1; s_cval = 12'h000; step();
    for (int i = 0; i < 65536; i++) sb[i] = 0;
    sb_on = 1; done_cnt = 0; phase = 0;
    for (int i = 0; i < 80000 && e_busy; i++) begin
      idle();
      s_wv = 1'($urandom); s_wa = 16'($urandom); s_wd = 12'($urandom);
      if (m_cnt >= NWORDS / 2) begin
        s_blank = (phase % 64) >= 8;
        phase++;
        s_h = 11'($urandom_range(0, 1023));
        s_v = 10'($urandom_range(0, 767));
      end
      step();
    end
    check_eq("clear_timeout", clear_busy, 0);
    idle(); step();
    sb_on = 0;
    bad = 0;
    for (int i = 0; i < 65536; i++)
      if (sb[i] != ((i < NWORDS) ? 1 : 0)) bad++;
    check_eq("clear_coverage", bad, 0);
    check_eq("clear_done_count", done_cnt, 1);

    // Reset in the middle of a sweep
    idle(); s_creq = 1; s_cval = 12'h777; step();
    idle(); repeat (100) step();
    done_cnt = 0;
    idle(); s_rst = 1; step();
    check_eq("mid_rst_busy", clear_busy, 0);
    check_eq("mid_rst_we", mem_we, 0);
    check_eq("mid_rst_pix", pixel_out, 0);
    for (int i = 0; i < 300; i++) begin
      idle();
      s_blank = 1'($urandom);
      s_h = 11'($urandom_range(0, 1023));
      s_v = 10'($urandom_range(0, 767));
      step();
    end
    check_eq("mid_rst_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
